event_dispatch: RTL and testbench
=================================

# event_dispatch

Downstream consumer of the event priority queue in the PDES engine. Watches the queue's root element and occupancy, pops the minimum-timestamp event when a simulation core is idle and the event is inside the optimistic time window, and hands it to one core chosen round-robin. It also keeps pops spaced so the heap pipeline can settle between dequeues.

## Interface
Parameters:
- DW, 64: event word width; must equal the queue data width.
- TW, 16: timestamp width; timestamp is event bits [DW-1:DW-TW].
- HD, 5: queue count width.
- NUM_CORES, 8: number of simulation cores (2..16).
- SETTLE_CYC, 2: dead cycles after each pop (1..7).

Ports:
- CLK  in  1  clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- q_count  in  HD  queue occupancy.
- q_data  in  DW  queue root, the current minimum.
- q_enq  in  1  upstream enqueue to the queue this cycle.
- q_deq  out  1  dequeue strobe to the queue.
- core_req  in  NUM_CORES  per-core idle/request level.
- core_grant  out  NUM_CORES  one-hot grant, registered.
- ev_out  out  DW  dispatched event, registered.
- ev_valid  out  1  ev_out/core_grant valid, one cycle.
- gvt  in  TW  current global virtual time.
- window  in  TW  lookahead window width.
- ts_err  out  1  sticky: popped event had ts < gvt.
- dispatch_cnt  out  32  events dispatched, wraps.

## Operation
- States: IDLE, SETTLE. Reset enters IDLE.
- eligible = (q_count != 0) & |core_req & !q_enq & in_window.
- in_window: ts = q_data[DW-1:DW-TW]. Use TW+1-bit unsigned arithmetic with no wrap: true if ts < gvt, or ts - gvt <= window.
- q_deq = (state == IDLE) & eligible. This is combinational from registered state and the inputs. The queue gives enq priority, so q_enq blocks the pop.
- On a pop edge:
  - ev_out <= q_data, ev_valid <= 1.
  - core_grant <= round-robin pick of core_req.
  - dispatch_cnt += 1.
  - ts_err <= ts_err | (ts < gvt).
  - State moves to SETTLE with settle counter = SETTLE_CYC-1.
- Round-robin: search core_req from index ptr upward, wrapping. After granting core i, ptr <= (i+1) mod NUM_CORES. ptr resets to 0.
- SETTLE: q_deq = 0. Counter decrements each cycle; leave for IDLE on the cycle the counter is 0.
- ev_valid and core_grant clear the cycle after assertion. The granted core must drop core_req within SETTLE_CYC cycles.
- Reset values: q_deq 0, core_grant 0, ev_out 0, ev_valid 0, ts_err 0, dispatch_cnt 0, ptr 0, state IDLE.
- A reset mid-SETTLE or mid-grant discards everything; nothing is replayed.

## Timing
- Pop decision to grant: q_deq high in cycle t; ev_valid, core_grant and ev_out valid in cycle t+1.
- Minimum spacing between q_deq pulses is SETTLE_CYC+1 cycles.
- q_count is sampled as-is. A pop at q_count == 1 is legal. No pop occurs at 0.
- q_enq high while in IDLE delays the pop by one cycle per enqueue cycle. A continuous enqueue stream starves dispatch; that is accepted.
- gvt or window changes take effect on the next IDLE evaluation.

## Configuration
- DISPATCH_WINDOW_EN:
  - Defined: in_window is enforced as above.
  - Undefined: in_window is tied to 1, so any root event is dispatched. ts_err is still computed. window is unused.

## Test plan
- Reset with q_count=3 and core_req=8'h01 for 4 cycles, then release: outputs stay 0 during reset. First q_deq occurs in the first cycle after release; ev_valid follows one cycle later with core_grant=8'h01.
- q_count=4, core_req=8'hFF held, window=100, gvt=0, ts=10: q_deq pulses every 3 cycles with SETTLE_CYC=2. Grants rotate 0x01, 0x02, 0x04, 0x08.
- q_count=0 with requests present: q_deq never asserts and dispatch_cnt stays 0.
- q_enq=1 on the eligible cycle, low on the next: q_deq is 0, then 1 the following cycle.
- With DISPATCH_WINDOW_EN defined, gvt=100, window=20:
  - ts=121: no pop.
  - ts=120: pop.
  - ts=90: pop and ts_err=1, which stays 1.
  - Without the macro, ts=121 pops.
- gvt=16'hFFF0, window=16'h0020, ts=16'hFFFF: pop occurs, because the window arithmetic does not wrap.

Source files
------------

// File: rtl/event_dispatch.sv
// Event dispatcher: pops the minimum-timestamp root from the event queue and hands it to an idle core round-robin.
// Optional macro DISPATCH_WINDOW_EN enforces the optimistic time window; otherwise every root event is eligible.
module event_dispatch #(
    parameter int DW         = 64,
    parameter int TW         = 16,
    parameter int HD         = 5,
    parameter int NUM_CORES  = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic [HD-1:0]        q_count,
    input  logic [DW-1:0]        q_data,
    input  logic                 q_enq,
    output logic                 q_deq,
    input  logic [NUM_CORES-1:0] core_req,
    output logic [NUM_CORES-1:0] core_grant,
    output logic [DW-1:0]        ev_out,
    output logic                 ev_valid,
    input  logic [TW-1:0]        gvt,
    input  logic [TW-1:0]        window,
    output logic                 ts_err,
    output logic [31:0]          dispatch_cnt
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           settle_q, settle_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NUM_CORES-1:0] core_grant_q, core_grant_d;
    logic [DW-1:0]        ev_out_q, ev_out_d;
    logic                 ev_valid_q, ev_valid_d;
    logic                 ts_err_q, ts_err_d;
    logic [31:0]          dispatch_cnt_q, dispatch_cnt_d;

    logic [TW-1:0]        ts;
    logic                 ts_late;
    logic                 in_window;
    logic                 eligible;
    logic                 pop;
    logic                 pick_found;
    logic [PW-1:0]        pick_idx;
    int                   rr_idx;

    assign ts      = q_data[DW-1 -: TW];
    assign ts_late = (ts < gvt);

`ifdef DISPATCH_WINDOW_EN
    // Extra bit keeps ts - gvt from wrapping when gvt sits near the top of its range.
    logic [TW:0] ts_ahead;
    assign ts_ahead  = {1'b0, ts} - {1'b0, gvt};
    assign in_window = ts_late || (ts_ahead <= {1'b0, window});
`else
    logic unused_window;
    assign unused_window = ^window;
    assign in_window     = 1'b1;
`endif

    // The queue services enqueues first, so a concurrent enqueue blocks the pop.
    assign eligible = (q_count != '0) && (|core_req) && !q_enq && in_window;
    assign pop      = rst_n && (state_q == IDLE) && eligible;
    assign q_deq    = pop;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        rr_idx     = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            rr_idx = (int'(ptr_q) + k) % NUM_CORES;
            if (!pick_found && core_req[rr_idx]) begin
                pick_found = 1'b1;
                pick_idx   = rr_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        settle_d       = settle_q;
        ptr_d          = ptr_q;
        core_grant_d   = '0;
        ev_out_d       = ev_out_q;
        ev_valid_d     = 1'b0;
        ts_err_d       = ts_err_q;
        dispatch_cnt_d = dispatch_cnt_q;
        case (state_q)
            IDLE: begin
                if (pop && pick_found) begin
                    state_d        = SETTLE;
                    settle_d       = 3'(SETTLE_CYC - 1);
                    ptr_d          = (pick_idx == PW'(NUM_CORES - 1)) ? '0 : pick_idx + 1'b1;
                    core_grant_d   = {{(NUM_CORES-1){1'b0}}, 1'b1} << pick_idx;
                    ev_out_d       = q_data;
                    ev_valid_d     = 1'b1;
                    ts_err_d       = ts_err_q | ts_late;
                    dispatch_cnt_d = dispatch_cnt_q + 32'd1;
                end
            end
            SETTLE: begin
                if (settle_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            settle_q       <= '0;
            ptr_q          <= '0;
            core_grant_q   <= '0;
            ev_out_q       <= '0;
            ev_valid_q     <= 1'b0;
            ts_err_q       <= 1'b0;
            dispatch_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            ptr_q          <= ptr_d;
            core_grant_q   <= core_grant_d;
            ev_out_q       <= ev_out_d;
            ev_valid_q     <= ev_valid_d;
            ts_err_q       <= ts_err_d;
            dispatch_cnt_q <= dispatch_cnt_d;
        end
    end

    assign core_grant   = core_grant_q;
    assign ev_out       = ev_out_q;
    assign ev_valid     = ev_valid_q;
    assign ts_err       = ts_err_q;
    assign dispatch_cnt = dispatch_cnt_q;

endmodule

// File: tb/tb_event_dispatch.sv
// Self-checking bench for event_dispatch: directed test-plan steps plus randomized traffic against a cycle-level reference model.
module tb_event_dispatch;

    localparam int DW = 64;
    localparam int TW = 16;
    localparam int HD = 5;
    localparam int NC = 8;
    localparam int SC = 2;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic [HD-1:0] q_count;
    logic [DW-1:0] q_data;
    logic          q_enq;
    logic          q_deq;
    logic [NC-1:0] core_req;
    logic [NC-1:0] core_grant;
    logic [DW-1:0] ev_out;
    logic          ev_valid;
    logic [TW-1:0] gvt;
    logic [TW-1:0] window;
    logic          ts_err;
    logic [31:0]   dispatch_cnt;

    event_dispatch #(.DW(DW), .TW(TW), .HD(HD), .NUM_CORES(NC), .SETTLE_CYC(SC)) dut (
        .CLK(CLK), .rst_n(rst_n), .q_count(q_count), .q_data(q_data), .q_enq(q_enq),
        .q_deq(q_deq), .core_req(core_req), .core_grant(core_grant), .ev_out(ev_out),
        .ev_valid(ev_valid), .gvt(gvt), .window(window), .ts_err(ts_err),
        .dispatch_cnt(dispatch_cnt)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: cooldown counts cycles until the next pop is allowed.
    int            m_cool = 0;
    int            m_ptr = 0;
    logic [31:0]   m_cnt = '0;
    logic          m_err = 1'b0;
    logic          m_valid = 1'b0;
    logic [NC-1:0] m_grant = '0;
    logic [DW-1:0] m_ev = '0;
    logic          obs_deq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int ts, input logic [47:0] low);
        logic [TW-1:0] t;
        t = TW'(ts);
        return {t, low};
    endfunction

    function automatic bit model_inwin();
        int t, g, w;
        t = int'(q_data[DW-1 -: TW]);
        g = int'(gvt);
        w = int'(window);
`ifdef DISPATCH_WINDOW_EN
        return (t < g) || (t - g <= w);
`else
        return (t >= 0) && (w >= 0);
`endif
    endfunction

    function automatic bit model_pop();
        return (rst_n === 1'b1) && (m_cool == 0) && (q_count != 0) && (core_req != 0)
               && (q_enq == 1'b0) && model_inwin();
    endfunction

    task automatic tick();
        bit exp_pop;
        @(negedge CLK);
        exp_pop = model_pop();
        obs_deq = q_deq;
        check("q_deq", {63'd0, q_deq}, {63'd0, exp_pop});
        @(posedge CLK);
        if (rst_n !== 1'b1) begin
            m_cool = 0; m_ptr = 0; m_cnt = '0; m_err = 1'b0;
            m_valid = 1'b0; m_grant = '0; m_ev = '0;
        end else if (exp_pop) begin
            int pick;
            pick = -1;
            for (int k = 0; k < NC; k++) begin
                int i;
                i = (m_ptr + k) % NC;
                if (pick < 0 && core_req[i]) pick = i;
            end
            m_grant = '0;
            m_grant[pick] = 1'b1;
            m_ptr   = (pick + 1) % NC;
            m_cnt   = m_cnt + 1;
            m_err   = m_err | (q_data[DW-1 -: TW] < gvt);
            m_ev    = q_data;
            m_valid = 1'b1;
            m_cool  = SC;
        end else begin
            m_valid = 1'b0;
            m_grant = '0;
            if (m_cool > 0) m_cool--;
        end
        #1;
        check("ev_valid", {63'd0, ev_valid}, {63'd0, m_valid});
        check("core_grant", {56'd0, core_grant}, {56'd0, m_grant});
        check("ev_out", ev_out, m_ev);
        check("ts_err", {63'd0, ts_err}, {63'd0, m_err});
        check("dispatch_cnt", {32'd0, dispatch_cnt}, {32'd0, m_cnt});
    endtask

    task automatic settle_out();
        q_count = '0;
        repeat (SC + 1) tick();
    endtask

    initial begin
        logic [NC-1:0] grants [4];
        int ng;
        int ndeq;

        // Reset held with a pending eligible event.
        rst_n = 1'b0; q_count = 5'd3; core_req = 8'h01; q_enq = 1'b0;
        gvt = '0; window = 16'd100; q_data = mk(10, 48'h0000_1234_5678);
        repeat (4) begin
            tick();
            check("rst_deq", {63'd0, obs_deq}, 64'd0);
            check("rst_valid", {63'd0, ev_valid}, 64'd0);
        end
        rst_n = 1'b1;
        tick();
        check("first_deq", {63'd0, obs_deq}, 64'd1);
        check("first_grant", {56'd0, core_grant}, 64'h01);
        check("first_valid", {63'd0, ev_valid}, 64'd1);
        tick();
        check("valid_clears", {63'd0, ev_valid}, 64'd0);

        // Round-robin rotation with all cores requesting.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        q_count = 5'd4; core_req = 8'hFF; q_data = mk(10, 48'hABCD);
        ng = 0; ndeq = 0;
        repeat (12) begin
            tick();
            if (obs_deq) ndeq++;
            if (ev_valid === 1'b1 && ng < 4) begin
                grants[ng] = core_grant;
                ng++;
            end
        end
        check("rr_deq_count", 64'(ndeq), 64'd4);
        check("rr_g0", {56'd0, grants[0]}, 64'h01);
        check("rr_g1", {56'd0, grants[1]}, 64'h02);
        check("rr_g2", {56'd0, grants[2]}, 64'h04);
        check("rr_g3", {56'd0, grants[3]}, 64'h08);

        // Empty queue never pops.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        q_count = '0; core_req = 8'hFF;
        repeat (6) tick();
        check("empty_cnt", {32'd0, dispatch_cnt}, 64'd0);

        // Enqueue blocks the pop for one cycle.
        q_count = 5'd2; q_enq = 1'b1;
        tick();
        check("enq_block", {63'd0, obs_deq}, 64'd0);
        q_enq = 1'b0;
        tick();
        check("enq_release", {63'd0, obs_deq}, 64'd1);
        settle_out();

        // Window edges.
        gvt = 16'd100; window = 16'd20; q_count = 5'd3;
        q_data = mk(121, 48'h121);
        tick();
`ifdef DISPATCH_WINDOW_EN
        check("win_121", {63'd0, obs_deq}, 64'd0);
`else
        check("win_121", {63'd0, obs_deq}, 64'd1);
`endif
        settle_out();
        q_count = 5'd3; q_data = mk(120, 48'h120);
        tick();
        check("win_120", {63'd0, obs_deq}, 64'd1);
        settle_out();
        q_count = 5'd1; q_data = mk(90, 48'h90);
        tick();
        check("win_90", {63'd0, obs_deq}, 64'd1);
        check("ts_err_set", {63'd0, ts_err}, 64'd1);
        settle_out();
        q_count = 5'd3; q_data = mk(110, 48'h110);
        repeat (4) tick();
        check("ts_err_sticky", {63'd0, ts_err}, 64'd1);
        settle_out();

        // Window arithmetic near the top of the timestamp range.
        gvt = 16'hFFF0; window = 16'h0020; q_count = 5'd2; q_data = mk(16'hFFFF, 48'hF);
        tick();
        check("win_nowrap", {63'd0, obs_deq}, 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            q_count  = HD'($urandom_range(0, 3));
            q_enq    = ($urandom_range(0, 4) == 0);
            core_req = ($urandom_range(0, 5) == 0) ? '0 : NC'($urandom);
            gvt      = ($urandom_range(0, 3) == 0) ? TW'(16'hFFC0 + $urandom_range(0, 63)) : TW'($urandom);
            window   = TW'($urandom_range(0, 80));
            if ($urandom_range(0, 1) == 0)
                q_data = mk(int'(gvt) + $urandom_range(0, 100) - 20, {$urandom, 16'($urandom)});
            else
                q_data = {$urandom, $urandom};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
